tri_clip_classify: RTL and testbench

Pipelined, parametrised successor to the single-triangle bounds test. It streams 3D triangles through a two-stage valid/ready pipeline and computes a per-vertex 6-bit clip outcode against a configurable view volume. Each triangle is classified as trivially accepted, trivially rejected or needing clipping, and rejected triangles can optionally be culled. It sits between the transform stage and the clipper/rasteriser front end.

---
 rtl/tri_clip_classify.sv | 166 ++++++++++++++++
 tb/tb_tri_clip_classify.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tri_clip_classify.sv
// Two-stage valid/ready triangle classifier: per-vertex 6-bit clip outcodes, accept/reject/clip.
// Define TRI_CLASSIFY_STATS_EN to add clr_stats and the saturating class counters.
module tri_clip_classify #(
    parameter int COORD_W = 16,
    parameter int XMIN    = -1024,
    parameter int XMAX    = 1023,
    parameter int YMIN    = -1024,
    parameter int YMAX    = 1023,
    parameter int ZMIN    = 0,
    parameter int ZMAX    = 1023,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [9*COORD_W-1:0] in_tri,
    input  logic                 cull_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [9*COORD_W-1:0] out_tri,
    output logic [1:0]           out_class,
    output logic [17:0]          out_outcode
`ifdef TRI_CLASSIFY_STATS_EN
    ,
    input  logic                 clr_stats,
    output logic [CNT_W-1:0]     cnt_accept,
    output logic [CNT_W-1:0]     cnt_reject,
    output logic [CNT_W-1:0]     cnt_clip
`endif
);

    localparam int TriW = 9 * COORD_W;

    typedef enum logic [1:0] {
        ClsAccept = 2'b00,
        ClsReject = 2'b01,
        ClsClip   = 2'b10
    } cls_e;

    // Bit order {z>max, z<min, y>max, y<min, x>max, x<min}; all compares signed, bounds inclusive.
    function automatic logic [5:0] vtx_outcode(input logic signed [COORD_W-1:0] x,
                                               input logic signed [COORD_W-1:0] y,
                                               input logic signed [COORD_W-1:0] z);
        int xi;
        int yi;
        int zi;
        xi = int'(x);
        yi = int'(y);
        zi = int'(z);
        return {zi > ZMAX, zi < ZMIN, yi > YMAX, yi < YMIN, xi > XMAX, xi < XMIN};
    endfunction

    logic [17:0]     in_oc;
    logic            in_fire;

    logic            s1_valid_q, s1_valid_d;
    logic [TriW-1:0] s1_tri_q;
    logic            s1_cull_q;
    logic [17:0]     s1_oc_q;
    cls_e            s1_class;
    logic            s1_rej;
    logic            s1_drop;
    logic            s1_xfer;
    logic            s1_pop;

    logic            s2_valid_q, s2_valid_d;
    logic [TriW-1:0] s2_tri_q;
    logic [1:0]      s2_class_q;
    logic [17:0]     s2_oc_q;
    logic            s2_load;

    // in_tri fields: p.x,q.x,r.x,p.y,q.y,r.y,p.z,q.z,r.z from MSB down; vertex v=0 is p.
    always_comb begin
        in_oc = '0;
        for (int v = 0; v < 3; v++) begin
            in_oc[(2-v)*6 +: 6] = vtx_outcode(in_tri[(8-v)*COORD_W +: COORD_W],
                                              in_tri[(5-v)*COORD_W +: COORD_W],
                                              in_tri[(2-v)*COORD_W +: COORD_W]);
        end
    end

    always_comb begin
        s1_rej = |(s1_oc_q[17:12] & s1_oc_q[11:6] & s1_oc_q[5:0]);
        if (s1_rej) begin
            s1_class = ClsReject;
        end else if (|(s1_oc_q[17:12] | s1_oc_q[11:6] | s1_oc_q[5:0])) begin
            s1_class = ClsClip;
        end else begin
            s1_class = ClsAccept;
        end
    end

    // A culled reject leaves S1 without needing S2, so it never blocks behind a stall.
    always_comb begin
        s1_drop    = s1_valid_q & s1_cull_q & s1_rej;
        s1_xfer    = s1_valid_q & (!s2_valid_q | out_ready);
        s1_pop     = s1_xfer | s1_drop;
        s2_load    = s1_xfer & !s1_drop;
        in_ready   = !rst & (!s1_valid_q | s1_pop);
        in_fire    = in_valid & in_ready;
        s1_valid_d = in_fire | (s1_valid_q & !s1_pop);
        s2_valid_d = s2_load | (s2_valid_q & !out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_tri_q   <= '0;
            s1_cull_q  <= 1'b0;
            s1_oc_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_tri_q   <= '0;
            s2_class_q <= ClsAccept;
            s2_oc_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_fire) begin
                s1_tri_q  <= in_tri;
                s1_cull_q <= cull_en;
                s1_oc_q   <= in_oc;
            end
            if (s2_load) begin
                s2_tri_q   <= s1_tri_q;
                s2_class_q <= s1_class;
                s2_oc_q    <= s1_oc_q;
            end
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_tri     = s2_tri_q;
    assign out_class   = s2_class_q;
    assign out_outcode = s2_oc_q;

`ifdef TRI_CLASSIFY_STATS_EN
    logic [CNT_W-1:0] cnt_accept_q;
    logic [CNT_W-1:0] cnt_reject_q;
    logic [CNT_W-1:0] cnt_clip_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Every triangle leaving S1 is counted once, culled rejects included.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            cnt_accept_q <= '0;
            cnt_reject_q <= '0;
            cnt_clip_q   <= '0;
        end else if (s1_pop) begin
            unique case (s1_class)
                ClsAccept: cnt_accept_q <= sat_inc(cnt_accept_q);
                ClsReject: cnt_reject_q <= sat_inc(cnt_reject_q);
                default:   cnt_clip_q   <= sat_inc(cnt_clip_q);
            endcase
        end
    end

    assign cnt_accept = cnt_accept_q;
    assign cnt_reject = cnt_reject_q;
    assign cnt_clip   = cnt_clip_q;
`endif

endmodule

// File: tb/tb_tri_clip_classify.sv
// Directed self-checking bench for tri_clip_classify; counter checks build with TRI_CLASSIFY_STATS_EN.
module tb_tri_clip_classify;

`ifdef TRI_CLASSIFY_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [143:0] in_tri;
    logic         cull_en;
    logic         out_valid;
    logic         out_ready;
    logic [143:0] out_tri;
    logic [1:0]   out_class;
    logic [17:0]  out_outcode;
`ifdef TRI_CLASSIFY_STATS_EN
    logic             clr_stats;
    logic [CNT_W-1:0] cnt_accept;
    logic [CNT_W-1:0] cnt_reject;
    logic [CNT_W-1:0] cnt_clip;
`endif

    int n_vec = 0;
    int n_err = 0;
    int sent;
    int got;
    logic [143:0] sq [5];
    logic [143:0] t1, t2, t3, t4, t5, tpri, ta, tb;

    always #5 clk = ~clk;

    tri_clip_classify #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_tri     (in_tri),
        .cull_en    (cull_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tri    (out_tri),
        .out_class  (out_class),
        .out_outcode(out_outcode)
`ifdef TRI_CLASSIFY_STATS_EN
        ,
        .clr_stats  (clr_stats),
        .cnt_accept (cnt_accept),
        .cnt_reject (cnt_reject),
        .cnt_clip   (cnt_clip)
`endif
    );

    function automatic logic [143:0] mk(input int px, input int py, input int pz,
                                        input int qx, input int qy, input int qz,
                                        input int rx, input int ry, input int rz);
        return {16'(px), 16'(qx), 16'(rx), 16'(py), 16'(qy), 16'(ry), 16'(pz), 16'(qz), 16'(rz)};
    endfunction

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one triangle, then watch it come out two edges later with out_ready high.
    task automatic send_one(input string tag, input logic [143:0] t, input logic c,
                            input logic ev, input logic [1:0] ec, input logic [17:0] eoc);
        in_valid  = 1'b1;
        in_tri    = t;
        cull_en   = c;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        in_tri   = '0;
        cull_en  = 1'b0;
        chk({tag, ".early"}, out_valid, 1'b0);
        step();
        chk({tag, ".valid"}, out_valid, ev);
        if (ev) begin
            chk({tag, ".tri"}, out_tri, t);
            chk({tag, ".class"}, out_class, ec);
            chk({tag, ".oc"}, out_outcode, eoc);
        end
        step();
        chk({tag, ".drained"}, out_valid, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_tri    = '0;
        cull_en   = 1'b0;
        out_ready = 1'b1;
`ifdef TRI_CLASSIFY_STATS_EN
        clr_stats = 1'b0;
`endif
        t1   = mk(0, 0, 10, 5, 5, 20, -5, 3, 30);
        t2   = mk(1023, 0, 5, 0, -1024, 5, 0, 0, 0);
        t3   = mk(1024, 0, 5, 0, -1024, 5, 0, 0, 0);
        t4   = mk(-1025, 0, 0, 0, 1024, 0, 0, -1025, 1024);
        t5   = mk(0, 0, -1, 1, 1, -1, 2, 2, -1);
        tpri = mk(2000, 0, 0, 1500, 2000, 0, 1100, 0, 2000);
        ta   = mk(7, 7, 7, 8, 8, 8, 9, 9, 9);
        tb   = mk(-7, 1, 2, -8, 3, 4, -9, 5, 6);
        for (int i = 0; i < 5; i++) sq[i] = mk(i, 2 * i, 3 * i + 1, -i, i, 7, 100 + i, -100, 50);

        // Reset state
        step();
        chk("rst.in_ready", in_ready, 1'b0);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.out_tri", out_tri, '0);
        chk("rst.out_class", out_class, 2'b00);
        chk("rst.out_oc", out_outcode, 18'h0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst.in_ready", in_ready, 1'b1);
`ifdef TRI_CLASSIFY_STATS_EN
        chk("rst.cnt_accept", cnt_accept, '0);
`endif

        send_one("t1", t1, 1'b0, 1'b1, 2'b00, 18'h0);
`ifdef TRI_CLASSIFY_STATS_EN
        chk("t1.cnt_accept", cnt_accept, 1);
`endif
        send_one("t2_bound", t2, 1'b0, 1'b1, 2'b00, 18'h0);
        send_one("t3_xmax", t3, 1'b0, 1'b1, 2'b10, 18'h02000);
        send_one("t4_mixed", t4, 1'b0, 1'b1, 2'b10, 18'h01224);
        send_one("t5_rej", t5, 1'b0, 1'b1, 2'b01, 18'h10410);
        send_one("t5_cull", t5, 1'b1, 1'b0, 2'b01, 18'h10410);
`ifdef TRI_CLASSIFY_STATS_EN
        chk("cull.cnt_reject", cnt_reject, 2);
        chk("cull.cnt_clip", cnt_clip, 2);
`endif
        send_one("tpri", tpri, 1'b0, 1'b1, 2'b01, 18'h022A2);

        // Back-to-back at full rate
        in_valid = 1'b1;
        in_tri   = t2;
        step();
        in_tri = t3;
        #1;
        chk("b2b.in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("b2b.first", out_tri, t2);
        chk("b2b.first_cls", out_class, 2'b00);
        step();
        chk("b2b.second_v", out_valid, 1'b1);
        chk("b2b.second", out_tri, t3);
        chk("b2b.second_cls", out_class, 2'b10);
        step();

        // Five-triangle stream with a four-cycle downstream stall
        sent = 0;
        got  = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = (c >= 4);
            in_valid  = (sent < 5);
            in_tri    = (sent < 5) ? sq[sent] : '0;
            #1;
            if (c < 2) chk("stall.in_ready_hi", in_ready, 1'b1);
            if (c == 2) begin
                chk("stall.sent_at_block", sent, 2);
                chk("stall.in_ready_lo", in_ready, 1'b0);
            end
            if (c == 2 || c == 3) begin
                chk("stall.hold_valid", out_valid, 1'b1);
                chk("stall.hold_tri", out_tri, sq[0]);
                chk("stall.hold_cls", out_class, 2'b00);
            end
            if (out_valid && out_ready) begin
                if (got < 5) chk("stall.order", out_tri, sq[got]);
                else chk("stall.extra_out", got, 4);
                got++;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        chk("stall.sent", sent, 5);
        chk("stall.got", got, 5);
        chk("stall.idle", out_valid, 1'b0);
`ifdef TRI_CLASSIFY_STATS_EN
        chk("sat.cnt_accept", cnt_accept, 3);
        in_valid = 1'b1;
        in_tri   = ta;
        step();
        in_valid  = 1'b0;
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("clr.cnt_accept", cnt_accept, 0);
        chk("clr.cnt_reject", cnt_reject, 0);
        step();
`endif

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tri    = ta;
        step();
        in_tri = tb;
        step();
        in_valid = 1'b0;
        chk("full.out_valid", out_valid, 1'b1);
        chk("full.in_ready", in_ready, 1'b0);
        rst = 1'b1;
        step();
        chk("midrst.out_valid", out_valid, 1'b0);
        chk("midrst.in_ready", in_ready, 1'b0);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("midrst.no_replay", out_valid, 1'b0);
        end
        chk("midrst.out_tri", out_tri, '0);
`ifdef TRI_CLASSIFY_STATS_EN
        chk("midrst.cnt_accept", cnt_accept, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
